// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan scheduler.
// Leading-zero blanking helper is only compiled when DISP_SCAN_LZB_EN is defined.
package disp_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  localparam logic [1:0] SLOT_DIG3 = 2'd3;
  localparam logic [1:0] SLOT_DIG0 = 2'd0;

  localparam logic [3:0] AN_DIG3    = 4'b0111;
  localparam logic [3:0] AN_DIG2    = 4'b1011;
  localparam logic [3:0] AN_DIG1    = 4'b1101;
  localparam logic [3:0] AN_DIG0    = 4'b1110;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  function automatic logic [3:0] anode_pat(input logic [1:0] slot);
    case (slot)
      2'd3:    return AN_DIG3;
      2'd2:    return AN_DIG2;
      2'd1:    return AN_DIG1;
      default: return AN_DIG0;
    endcase
  endfunction

  function automatic logic [3:0] slot_nibble(input logic [15:0] val, input logic [1:0] slot);
    case (slot)
      2'd3:    return val[15:12];
      2'd2:    return val[11:8];
      2'd1:    return val[7:4];
      default: return val[3:0];
    endcase
  endfunction

`ifdef DISP_SCAN_LZB_EN
  // A slot is dark when its digit and every more-significant digit are zero;
  // dig0 is always lit so a zero value still shows "0".
  function automatic logic lz_dark(input logic [15:0] val, input logic [1:0] slot);
    case (slot)
      2'd3:    return (val[15:12] == 4'h0);
      2'd2:    return (val[15:8] == 8'h00);
      2'd1:    return (val[15:4] == 12'h000);
      default: return 1'b0;
    endcase
  endfunction
`endif

endpackage

// File: rtl/disp_tick_gen.sv
// Slot timer for the display scan scheduler: counts 0..SLOT_DIV-1 while running
// and flags the last lit cycle, the second-to-last and the last cycle of a slot.
module disp_tick_gen #(
  parameter int unsigned SLOT_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic disp_clk,
  input  logic reset,
  input  logic run,
  output logic blank_start,
  output logic slot_end,
  output logic pre_end
);

  localparam int CNT_W = $clog2(SLOT_DIV);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(SLOT_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(SLOT_DIV - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign blank_start = run && (cnt_q == CNT_BLANK);
  assign slot_end    = run && (cnt_q == CNT_LAST);
  assign pre_end     = run && (cnt_q == CNT_PRE);

  // Counter holds at zero while stopped and wraps at the end of every slot.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || slot_end) cnt_d = '0;
    else                  cnt_d = cnt_q + CNT_W'(1);
  end

  // Slot counter register.
  always_ff @(posedge disp_clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan_scheduler.sv
// Multiplexed 4-digit display scan scheduler with a single-entry pending
// register committed only at frame boundaries (tear-free updates).
// Optional leading-zero blanking: define DISP_SCAN_LZB_EN.
//
// state   | meaning
// S_OFF   | scan disabled, anodes dark, counter/slot parked at dig3
// S_ON    | current slot's anode driven, dig_code holds its nibble
// S_BLANK | inter-digit blanking at the end of a slot, anodes dark
module disp_scan_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned SLOT_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        disp_clk,
  input  logic        reset,
  input  logic        en,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [3:0]  anodes,
  output logic [3:0]  dig_code,
  output logic        frame_done
);

  state_e      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  anodes_q, anodes_d;
  logic [3:0]  dig_code_q, dig_code_d;
  logic        frame_done_q, frame_done_d;
  logic        run, blank_start, slot_end, pre_end;
  logic        commit, accept;

  assign run        = en && (state_q != S_OFF);
  assign in_ready   = in_ready_q;
  assign anodes     = anodes_q;
  assign dig_code   = dig_code_q;
  assign frame_done = frame_done_q;

  disp_tick_gen #(
    .SLOT_DIV  (SLOT_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .disp_clk    (disp_clk),
    .reset       (reset),
    .run         (run),
    .blank_start (blank_start),
    .slot_end    (slot_end),
    .pre_end     (pre_end)
  );

  // Next-state, handshake and output look-ahead; outputs are registered from
  // the next-state values so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    commit     = 1'b0;
    accept     = in_valid && in_ready_q;

    if (!en) begin
      state_d = S_OFF;
      slot_d  = SLOT_DIG3;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_ON;
          slot_d  = SLOT_DIG3;
          commit  = pend_vld_q;
        end
        S_ON: begin
          if (blank_start) state_d = S_BLANK;
        end
        S_BLANK: begin
          if (slot_end) begin
            state_d = S_ON;
            slot_d  = slot_q - 2'd1;
            commit  = pend_vld_q && (slot_q == SLOT_DIG0);
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // Commit and accept are mutually exclusive: commit needs a full pending
    // register, accept needs an empty one.
    if (commit) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      pend_d     = in_data;
      pend_vld_d = 1'b1;
    end

    in_ready_d   = !pend_vld_d;
    frame_done_d = run && (slot_q == SLOT_DIG0) && pre_end;

    anodes_d = (state_d == S_ON) ? anode_pat(slot_d) : ANODES_OFF;
`ifdef DISP_SCAN_LZB_EN
    if (lz_dark(disp_d, slot_d)) anodes_d = ANODES_OFF;
`endif

    dig_code_d = dig_code_q;
    if (state_d == S_ON && state_q != S_ON) dig_code_d = slot_nibble(disp_d, slot_d);
  end

  // FSM, data and output registers.
  always_ff @(posedge disp_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_OFF;
      slot_q       <= SLOT_DIG3;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      anodes_q     <= ANODES_OFF;
      dig_code_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      in_ready_q   <= in_ready_d;
      anodes_q     <= anodes_d;
      dig_code_q   <= dig_code_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_disp_scan_scheduler.sv
// Self-checking bench for disp_scan_scheduler (SLOT_DIV=8, BLANK_CYC=2).
// A reference tracker holds accepted values in a queue until the frame
// boundary that should commit them; a monitor compares every cycle.
module tb_disp_scan_scheduler;

  localparam int SLOT_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * SLOT_DIV;

  logic        disp_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        en       = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data  = 16'h0;
  logic        in_ready;
  logic [3:0]  anodes;
  logic [3:0]  dig_code;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  disp_scan_scheduler #(
    .SLOT_DIV  (SLOT_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .disp_clk   (disp_clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .anodes     (anodes),
    .dig_code   (dig_code),
    .frame_done (frame_done)
  );

  always #5 disp_clk = ~disp_clk;

  // Reference state: pending values queue, committed display, frame position.
  logic [15:0] exp_q[$];
  logic [15:0] m_disp   = 16'h0;
  bit          m_run    = 1'b0;
  bit          m_rdy_ok = 1'b0;
  int          m_pos    = 0;
  bit          m_pend, m_acc;

  function automatic logic [3:0] exp_nib(input logic [15:0] v, input int slot);
    logic [15:0] t;
    t = v >> (4 * slot);
    return t[3:0];
  endfunction

  function automatic logic [3:0] exp_anodes(input bit run, input int pos, input logic [15:0] disp);
    int slot;
    logic [15:0] hi;
    slot = 3 - pos / SLOT_DIV;
    if (!run || (pos % SLOT_DIV) >= SLOT_DIV - BLANK_CYC) return 4'b1111;
`ifdef DISP_SCAN_LZB_EN
    hi = disp >> (4 * slot);
    if (slot != 0 && hi == 16'h0) return 4'b1111;
`else
    hi = disp;
`endif
    case (slot)
      3:       return 4'b0111;
      2:       return 4'b1011;
      1:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  // Reference update at each active edge (or async reset).
  initial forever begin
    @(posedge disp_clk or negedge reset);
    if (!reset) begin
      exp_q.delete();
      m_disp   = 16'h0;
      m_run    = 1'b0;
      m_pos    = 0;
      m_rdy_ok = 1'b0;
    end else begin
      m_pend = (exp_q.size() != 0);
      m_acc  = in_valid && m_rdy_ok && !m_pend;
      if (!en) begin
        m_run = 1'b0;
        m_pos = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_pos = 0;
        if (m_pend) m_disp = exp_q.pop_front();
      end else begin
        if (m_pos == FRAME - 1 && m_pend) m_disp = exp_q.pop_front();
        m_pos = (m_pos + 1) % FRAME;
      end
      if (m_acc) exp_q.push_back(in_data);
      m_rdy_ok = 1'b1;
    end
  end

  // Scoreboard compare on the falling edge.
  logic       e_rdy, e_fd;
  logic [3:0] e_an, e_dc;
  initial forever begin
    @(negedge disp_clk);
    if (reset && m_rdy_ok) begin
      e_rdy = (exp_q.size() == 0);
      e_an  = exp_anodes(m_run, m_pos, m_disp);
      e_fd  = m_run && (m_pos == FRAME - 1);
      e_dc  = exp_nib(m_disp, 3 - m_pos / SLOT_DIV);
      checks++;
      if (in_ready !== e_rdy) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t pos=%0d got=%b exp=%b", $time, m_pos, in_ready, e_rdy);
      end
      checks++;
      if (anodes !== e_an) begin
        errors++;
        $display("FAIL sb_anodes t=%0t pos=%0d got=%b exp=%b", $time, m_pos, anodes, e_an);
      end
      checks++;
      if (frame_done !== e_fd) begin
        errors++;
        $display("FAIL sb_frame_done t=%0t pos=%0d got=%b exp=%b", $time, m_pos, frame_done, e_fd);
      end
      if (m_run) begin
        checks++;
        if (dig_code !== e_dc) begin
          errors++;
          $display("FAIL sb_dig_code t=%0t pos=%0d got=%h exp=%h", $time, m_pos, dig_code, e_dc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge disp_clk);
      #1;
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1);
      if (frame_done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_frame_timeout got=no_pulse exp=pulse");
  endtask

  task automatic wait_anodes(input logic [3:0] pat);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1);
      if (anodes === pat) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_anodes_timeout got=%b exp=%b", anodes, pat);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #10;
    checks++; if (anodes !== 4'b1111) begin errors++; $display("FAIL rst_anodes got=%b exp=1111", anodes); end
    checks++; if (dig_code !== 4'h0) begin errors++; $display("FAIL rst_dig_code got=%h exp=0", dig_code); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    step(2);
    en    = 1'b1;
    reset = 1'b1;
  endtask

  task automatic test_scan_idle();
    int fd_cnt;
    int first_fd;
    logic [3:0] a0;
    fd_cnt   = 0;
    first_fd = -1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(1);
      if (k == 0) begin
`ifdef DISP_SCAN_LZB_EN
        a0 = 4'b1111;
`else
        a0 = 4'b0111;
`endif
        checks++; if (anodes !== a0) begin errors++; $display("FAIL idle_first_anodes got=%b exp=%b", anodes, a0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_first_ready got=%b exp=1", in_ready); end
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (first_fd < 0) first_fd = k;
      end
    end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL idle_fd_count got=%0d exp=2", fd_cnt); end
    checks++; if (first_fd != FRAME - 1) begin errors++; $display("FAIL idle_fd_first got=%0d exp=%0d", first_fd, FRAME - 1); end
  endtask

  task automatic test_load();
    wait_frame();
    step(11);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step(1);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_low got=%b exp=0", in_ready); end
    wait_frame();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_at_boundary got=%b exp=0", in_ready); end
    step(1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready_rise got=%b exp=1", in_ready); end
    checks++; if (dig_code !== 4'h1) begin errors++; $display("FAIL load_dig3 got=%h exp=1", dig_code); end
    for (int i = 2; i <= 4; i++) begin
      step(SLOT_DIV);
      checks++;
      if (dig_code !== 4'(i)) begin errors++; $display("FAIL load_slot_digit got=%h exp=%0d", dig_code, i); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    step(1);
    in_data = 16'hABCD;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got=%b exp=0", in_ready); end
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      step(1);
      n++;
      if (in_ready === 1'b1) seen = 1'b1;
    end
    checks++; if (n != 7 || !seen) begin errors++; $display("FAIL b2b_ready_wait got=%0d exp=7", n); end
    checks++; if (dig_code !== 4'h5) begin errors++; $display("FAIL b2b_first_commit got=%h exp=5", dig_code); end
    step(1);
    in_valid = 1'b0;
    wait_frame();
    step(1);
    checks++; if (dig_code !== 4'hA) begin errors++; $display("FAIL b2b_second_dig3 got=%h exp=a", dig_code); end
    step(SLOT_DIV);
    checks++; if (dig_code !== 4'hB) begin errors++; $display("FAIL b2b_second_dig2 got=%h exp=b", dig_code); end
  endtask

  task automatic test_en_toggle();
    step(9);
    en = 1'b0;
    step(1);
    checks++; if (anodes !== 4'b1111) begin errors++; $display("FAIL en_off_anodes got=%b exp=1111", anodes); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL en_off_fd got=%b exp=0", frame_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_off_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1;
    in_data  = 16'h2468;
    step(1);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_off_accept got=%b exp=0", in_ready); end
    step(3);
    en = 1'b1;
    step(1);
    checks++; if (anodes !== 4'b0111) begin errors++; $display("FAIL en_restart_anodes got=%b exp=0111", anodes); end
    checks++; if (dig_code !== 4'h2) begin errors++; $display("FAIL en_entry_commit got=%h exp=2", dig_code); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_entry_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_lzb();
    logic [3:0] e3, e2;
`ifdef DISP_SCAN_LZB_EN
    e3 = 4'b1111;
    e2 = 4'b1111;
`else
    e3 = 4'b0111;
    e2 = 4'b1011;
`endif
    in_valid = 1'b1;
    in_data  = 16'h0050;
    step(1);
    in_valid = 1'b0;
    wait_frame();
    step(1);
    checks++; if (anodes !== e3) begin errors++; $display("FAIL lzb_dig3 got=%b exp=%b", anodes, e3); end
    step(SLOT_DIV);
    checks++; if (anodes !== e2) begin errors++; $display("FAIL lzb_dig2 got=%b exp=%b", anodes, e2); end
    step(SLOT_DIV);
    checks++; if (anodes !== 4'b1101 || dig_code !== 4'h5) begin errors++; $display("FAIL lzb_dig1 got=%b/%h exp=1101/5", anodes, dig_code); end
    step(SLOT_DIV);
    checks++; if (anodes !== 4'b1110 || dig_code !== 4'h0) begin errors++; $display("FAIL lzb_dig0 got=%b/%h exp=1110/0", anodes, dig_code); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e3;
`ifdef DISP_SCAN_LZB_EN
    e3 = 4'b1111;
`else
    e3 = 4'b0111;
`endif
    step(SLOT_DIV);
    in_valid = 1'b1;
    in_data  = 16'h9999;
    step(1);
    in_valid = 1'b0;
    wait_anodes(4'b1101);
    step(SLOT_DIV - BLANK_CYC);
    checks++; if (anodes !== 4'b1111) begin errors++; $display("FAIL rmid_in_blank got=%b exp=1111", anodes); end
    #1 reset = 1'b0;
    #1;
    checks++; if (anodes !== 4'b1111) begin errors++; $display("FAIL rmid_anodes got=%b exp=1111", anodes); end
    checks++; if (dig_code !== 4'h0) begin errors++; $display("FAIL rmid_dig_code got=%h exp=0", dig_code); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_frame_done got=%b exp=0", frame_done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    step(2);
    reset = 1'b1;
    step(1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_release_ready got=%b exp=1", in_ready); end
    checks++; if (anodes !== e3) begin errors++; $display("FAIL rmid_release_anodes got=%b exp=%b", anodes, e3); end
    wait_frame();
    step(1);
    checks++; if (dig_code !== 4'h0) begin errors++; $display("FAIL rmid_no_commit got=%h exp=0", dig_code); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_pend_dropped got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_load();
    test_back_to_back();
    test_en_toggle();
    test_lzb();
    test_reset_mid();
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
